// File: rtl/grid_position_tracker.sv
// rtl/grid_position_tracker.sv - maps a pixel (x,y) to a grid cell by iterative per-axis subtraction.
// Optional build macro POS_CLAMP_EN: clamp out-of-grid axes instead of reporting sentinel COLS/ROWS.
module grid_position_tracker #(
  parameter int COORD_W  = 10,
  parameter int ORIGIN_X = 240,
  parameter int ORIGIN_Y = 60,
  parameter int CELL_W   = 20,
  parameter int CELL_H   = 20,
  parameter int COLS     = 10,
  parameter int ROWS     = 20,
  parameter int CW       = $clog2(COLS + 1),
  parameter int RW       = $clog2(ROWS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CW-1:0]      col,
  output logic [RW-1:0]      row,
  output logic               oob
);

  localparam logic [COORD_W-1:0] ORIGIN_X_C = COORD_W'(ORIGIN_X);
  localparam logic [COORD_W-1:0] ORIGIN_Y_C = COORD_W'(ORIGIN_Y);
  localparam logic [COORD_W-1:0] CELL_W_C   = COORD_W'(CELL_W);
  localparam logic [COORD_W-1:0] CELL_H_C   = COORD_W'(CELL_H);
  localparam logic [CW-1:0]      COLS_C     = CW'(COLS);
  localparam logic [RW-1:0]      ROWS_C     = RW'(ROWS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state;
  logic [COORD_W-1:0]   dx;
  logic [COORD_W-1:0]   dy;
  logic                 below_x;
  logic                 below_y;
  logic [CW-1:0]        col_cnt;
  logic [RW-1:0]        row_cnt;

  logic                 step_x;
  logic                 step_y;
  logic                 oob_x;
  logic                 oob_y;
  logic [CW-1:0]        col_res;
  logic [RW-1:0]        row_res;

  // A counter that reached COLS/ROWS means the remainder still covered the grid: beyond range.
  always_comb begin
    step_x = !below_x && (dx >= CELL_W_C) && (col_cnt < COLS_C);
    step_y = !below_y && (dy >= CELL_H_C) && (row_cnt < ROWS_C);
    oob_x  = below_x || (col_cnt == COLS_C);
    oob_y  = below_y || (row_cnt == ROWS_C);
`ifdef POS_CLAMP_EN
    col_res = below_x ? '0 : ((col_cnt == COLS_C) ? CW'(COLS - 1) : col_cnt);
    row_res = below_y ? '0 : ((row_cnt == ROWS_C) ? RW'(ROWS - 1) : row_cnt);
`else
    col_res = oob_x ? COLS_C : col_cnt;
    row_res = oob_y ? ROWS_C : row_cnt;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      dx        <= '0;
      dy        <= '0;
      below_x   <= 1'b0;
      below_y   <= 1'b0;
      col_cnt   <= '0;
      row_cnt   <= '0;
      col       <= '0;
      row       <= '0;
      oob       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dx       <= x - ORIGIN_X_C;
            dy       <= y - ORIGIN_Y_C;
            below_x  <= x < ORIGIN_X_C;
            below_y  <= y < ORIGIN_Y_C;
            col_cnt  <= '0;
            row_cnt  <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (step_x) begin
            dx      <= dx - CELL_W_C;
            col_cnt <= col_cnt + 1'b1;
          end
          if (step_y) begin
            dy      <= dy - CELL_H_C;
            row_cnt <= row_cnt + 1'b1;
          end
          if (!step_x && !step_y) begin
            col       <= col_res;
            row       <= row_res;
            oob       <= oob_x || oob_y;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grid_position_tracker.sv
// tb/tb_grid_position_tracker.sv - randomized self-checking bench for grid_position_tracker.
module tb_grid_position_tracker;

  localparam int COORD_W  = 10;
  localparam int ORIGIN_X = 240;
  localparam int ORIGIN_Y = 60;
  localparam int CELL_W   = 20;
  localparam int CELL_H   = 20;
  localparam int COLS     = 10;
  localparam int ROWS     = 20;
  localparam int CW       = $clog2(COLS + 1);
  localparam int RW       = $clog2(ROWS + 1);

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [COORD_W-1:0] x = '0;
  logic [COORD_W-1:0] y = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic               oob;

  int errors = 0;
  int checks = 0;

  grid_position_tracker #(
    .COORD_W(COORD_W), .ORIGIN_X(ORIGIN_X), .ORIGIN_Y(ORIGIN_Y),
    .CELL_W(CELL_W), .CELL_H(CELL_H), .COLS(COLS), .ROWS(ROWS)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .col(col), .row(row), .oob(oob)
  );

  always #5 clk = ~clk;

  // Reference: cell index is floor division; the search saturates at the grid size.
  function automatic void model(input int xi, input int yi,
                                output int ec, output int er, output int eo, output int el);
    int qx, qy, sx, sy;
    bit bx, by, ox, oy;
    bx = xi < ORIGIN_X;
    by = yi < ORIGIN_Y;
    qx = bx ? 0 : (xi - ORIGIN_X) / CELL_W;
    qy = by ? 0 : (yi - ORIGIN_Y) / CELL_H;
    sx = (qx > COLS) ? COLS : qx;
    sy = (qy > ROWS) ? ROWS : qy;
    ox = bx || (qx >= COLS);
    oy = by || (qy >= ROWS);
`ifdef POS_CLAMP_EN
    ec = bx ? 0 : (ox ? COLS - 1 : qx);
    er = by ? 0 : (oy ? ROWS - 1 : qy);
`else
    ec = ox ? COLS : qx;
    er = oy ? ROWS : qy;
`endif
    eo = (ox || oy) ? 1 : 0;
    el = ((sx > sy) ? sx : sy) + 2;
  endfunction

  // Issues one request and returns edges from acceptance (inclusive) to out_valid, or -1 on timeout.
  task automatic run_req(input int xi, input int yi, output int lat);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    x = COORD_W'(xi);
    y = COORD_W'(yi);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || col !== '0 || row !== '0 || oob !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%0b col=%0d row=%0d oob=%0b want 0/0/0/0", out_valid, col, row, oob);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %0b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    int xs[3] = '{240, 425, 440};
    int ys[3] = '{60, 439, 40};
    int ec, er, eo, el, lat;
    for (int i = 0; i < 3; i++) begin
      model(xs[i], ys[i], ec, er, eo, el);
      run_req(xs[i], ys[i], lat);
      checks++;
      if (lat !== el || col !== CW'(ec) || row !== RW'(er) || oob !== eo[0]) begin
        errors++;
        $display("FAIL directed_%0d: got lat=%0d col=%0d row=%0d oob=%0b want lat=%0d col=%0d row=%0d oob=%0d",
                 i, lat, col, row, oob, el, ec, er, eo);
      end
      release_out();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL directed_release_%0d: got in_ready=%0b out_valid=%0b want 1/0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_hold();
    int lat;
    bit bad;
    run_req(260, 80, lat);
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = (c == 2);
      x = 10'd500;
      y = 10'd500;
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || col !== CW'(1) || row !== RW'(1) || oob !== 1'b0) bad = 1'b1;
    end
    in_valid = 1'b0;
    checks++;
    if (bad || lat !== 3) begin
      errors++;
      $display("FAIL hold_done: lat=%0d valid=%0b ready=%0b col=%0d row=%0d want lat=3 held 1/0/1/1", lat, out_valid, in_ready, col, row);
    end
    release_out();
    bad = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL hold_pulse_ignored: got valid=%0b ready=%0b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    @(negedge clk);
    x = 10'd425;
    y = 10'd439;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || col !== '0 || row !== '0 || oob !== 1'b0) begin
      errors++;
      $display("FAIL midrun_async_reset: got valid=%0b col=%0d row=%0d oob=%0b want 0/0/0/0", out_valid, col, row, oob);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrun_release: got ready=%0b valid=%0b want 1/0", in_ready, out_valid);
    end
    run_req(260, 80, lat);
    checks++;
    if (lat !== 3 || col !== CW'(1) || row !== RW'(1) || oob !== 1'b0) begin
      errors++;
      $display("FAIL midrun_new_req: got lat=%0d col=%0d row=%0d oob=%0b want 3/1/1/0", lat, col, row, oob);
    end
    release_out();
  endtask

  task automatic test_random();
    int xi, yi, ec, er, eo, el, lat, hold;
    bit bad;
    for (int n = 0; n < 40; n++) begin
      xi = (n % 8 == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(200, 480));
      yi = (n % 8 == 1) ? int'($urandom_range(0, 1023)) : int'($urandom_range(30, 500));
      model(xi, yi, ec, er, eo, el);
      run_req(xi, yi, lat);
      checks++;
      if (lat !== el || col !== CW'(ec) || row !== RW'(er) || oob !== eo[0]) begin
        errors++;
        $display("FAIL random_%0d x=%0d y=%0d: got lat=%0d col=%0d row=%0d oob=%0b want lat=%0d col=%0d row=%0d oob=%0d",
                 n, xi, yi, lat, col, row, oob, el, ec, er, eo);
      end
      hold = $urandom_range(0, 3);
      bad = 1'b0;
      repeat (hold) begin
        @(posedge clk);
        #1;
        if (out_valid !== 1'b1 || col !== CW'(ec) || row !== RW'(er)) bad = 1'b1;
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL random_hold_%0d: got valid=%0b col=%0d row=%0d want 1/%0d/%0d", n, out_valid, col, row, ec, er);
      end
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
